timer_int_ctrl: RTL and testbench
=================================

Name: timer_int_ctrl

Overview:
- Compare-and-interrupt stage of the 64-bit timer. Sits directly downstream of the counter and register blocks.
- Compares the live 64-bit count against the 64-bit compare value in a two-stage pipeline and detects the rising edge of a match.
- Holds the sticky interrupt status bit (TISR.int_st), which software clears by writing 1 to it.
- Drives the interrupt output tim_int as status gated by enable.

Parameters:
- HALF_W, 32, width of each compare half; the full compare width is 2*HALF_W = 64.
- CLR_BIT, 0, bit position of the W1C status bit within wdata/TISR.

Ports:
- sys_clk  in  1  system clock, all logic on rising edge
- sys_rst_n  in  1  asynchronous active-low reset
- cnt  in  64  live counter value from counter block
- tcmp  in  64  compare value {TCMP1,TCMP0} from register block
- int_en  in  1  TIER.int_en from register block
- tisr_wr_sel  in  1  APB write strobe to TISR, one cycle, from register block
- wdata  in  32  APB write data
- pstrb  in  4  APB byte strobes
- int_st  out  1  sticky interrupt status, read back via TISR
- tim_int  out  1  interrupt request to system

Behaviour:
- Clock and reset:
  - One clock, sys_clk.
  - Reset sys_rst_n is asynchronous, active-low.
  - All flops clear or preset on assertion; outputs are registered or derived from registered state.
- Reset values:
  - int_st=0, tim_int=0.
  - eq_lo_q=1, eq_hi_q=1, match_q=1.
  - The match history is preset to 1, so an equality already present at reset release does NOT set int_st. The count must leave and re-enter equality to trigger.
- Stage 1 (registered):
  - eq_lo_q <= (cnt[31:0]==tcmp[31:0]).
  - eq_hi_q <= (cnt[63:32]==tcmp[63:32]).
- Stage 2:
  - match_c = eq_lo_q & eq_hi_q.
  - match_q <= match_c.
  - rise = match_c & ~match_q.
- Set condition: set = rise.
- Clear condition: clr = tisr_wr_sel & pstrb[CLR_BIT/8] & wdata[CLR_BIT]. A write of 0, or with the byte strobe low, has no effect.
- int_st update:
  - int_st <= set ? 1 : (clr ? 0 : int_st).
  - Set wins over a simultaneous clear; no event is lost.
- Latency:
  - cnt==tcmp sampled at edge E0 → int_st=1 after edge E0+1, i.e. visible two cycles after equality is presented.
  - A clear write in cycle w → int_st=0 in cycle w+1.
- Output: tim_int = int_st & int_en (combinational AND of registered int_st and register bit).
  - Toggling int_en masks or unmasks tim_int the same cycle.
  - int_st is unaffected by int_en; status is still captured while masked.
- Stalled counter: if cnt stays equal to tcmp (halted, debug mode), rise fires only once. A clear while equality persists leaves int_st=0.
- tcmp rewritten: tcmp rewritten to a value equal to a stationary cnt produces a new rise and sets int_st. Equality must be absent for at least one sampled cycle before a new rise.
- Wrap-around: the comparison is purely on equality. A wrap from 0xFFFF_FFFF_FFFF_FFFF to 0 matches only if tcmp equals the new value; there is no magnitude compare.
- Counter clear: no special handling. Equality after cnt clears to 0 behaves like any other match.
- Reset mid-operation: asynchronous, immediate. int_st and tim_int drop in the same cycle; the pipeline is re-preset.

Optional Feature:
- Macro: TIM_INT_OVF_EN.
- Defined:
  - Adds output int_ovf (1 bit) and a 4-bit saturating counter miss_cnt.
  - miss_cnt increments on any rise while int_st is already 1, saturates at 15, and clears together with int_st on a valid clear.
  - A clear in the same cycle as a rise leaves miss_cnt=0, because the set wins and that event is not a miss.
  - int_ovf = (miss_cnt != 0), registered; reset value 0.
- Undefined: neither int_ovf nor miss_cnt exists; behaviour is otherwise identical.

Test Plan:
- Reset with cnt=tcmp=0, release reset, hold values → int_st stays 0, tim_int stays 0.
- tcmp=0x0000_0001_0000_0010, int_en=1, cnt counts up through 0x0000_0001_0000_0010 → int_st=1 and tim_int=1 exactly two cycles after cnt equals tcmp; they remain 1 after cnt passes.
- With int_st=1: write TISR wdata=0x1, pstrb=4'b0001 → int_st=0 next cycle. Write wdata=0x1, pstrb=4'b0010 → no change. Write wdata=0x0, pstrb=4'b0001 → no change.
- Same-cycle rise and clear write → int_st remains 1. With TIM_INT_OVF_EN, miss_cnt stays 0.
- Hold cnt equal to tcmp for 20 cycles with int_en=0, clear mid-way → int_st set once, clears, is not re-set; tim_int=0 throughout. Set int_en=1 before the clear → tim_int follows int_st that cycle.
- With TIM_INT_OVF_EN, tcmp rewritten to produce 17 rises without a clear → miss_cnt saturates at 15, int_ovf=1. One clear → int_st=0, miss_cnt=0, int_ovf=0 next cycle.

Source files
------------

// File: rtl/timer_int_ctrl.sv
// timer_int_ctrl: compare-and-interrupt stage of the 64-bit timer.
// Two-stage equality pipeline, rising-edge match detect, sticky W1C status
// and masked interrupt output.
// Optional build macro TIM_INT_OVF_EN adds a saturating missed-event counter
// and the int_ovf output.
module timer_int_ctrl #(
    parameter int unsigned HALF_W  = 32,
    parameter int unsigned CLR_BIT = 0
) (
    input  logic                sys_clk,
    input  logic                sys_rst_n,
    input  logic [2*HALF_W-1:0] cnt,
    input  logic [2*HALF_W-1:0] tcmp,
    input  logic                int_en,
    input  logic                tisr_wr_sel,
    input  logic [31:0]         wdata,
    input  logic [3:0]          pstrb,
`ifdef TIM_INT_OVF_EN
    output logic                int_ovf,
`endif
    output logic                int_st,
    output logic                tim_int
);

    localparam int unsigned CMP_W    = 2 * HALF_W;
    localparam int unsigned STRB_IDX = CLR_BIT / 8;

    logic eq_lo_q, eq_lo_d;
    logic eq_hi_q, eq_hi_d;
    logic match_q, match_c;
    logic rise_c;
    logic clr_c;
    logic int_st_q, int_st_d;

    // Only the status bit and its byte strobe matter; the rest is ignored.
    logic unused_wbits;
    assign unused_wbits = ^{wdata, pstrb};

    // Next-state: per-half equality, match edge, W1C clear, set-over-clear status.
    always_comb begin
        eq_lo_d  = 1'b0;
        eq_hi_d  = 1'b0;
        match_c  = 1'b0;
        rise_c   = 1'b0;
        clr_c    = 1'b0;
        int_st_d = int_st_q;

        eq_lo_d  = (cnt[HALF_W-1:0] == tcmp[HALF_W-1:0]);
        eq_hi_d  = (cnt[CMP_W-1:HALF_W] == tcmp[CMP_W-1:HALF_W]);
        match_c  = eq_lo_q & eq_hi_q;
        rise_c   = match_c & ~match_q;
        clr_c    = tisr_wr_sel & pstrb[STRB_IDX] & wdata[CLR_BIT];

        if (rise_c) begin
            int_st_d = 1'b1;
        end else if (clr_c) begin
            int_st_d = 1'b0;
        end
    end

    // Pipeline and status registers; match history presets to 1 so a match
    // already present at reset release is not reported.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            eq_lo_q  <= 1'b1;
            eq_hi_q  <= 1'b1;
            match_q  <= 1'b1;
            int_st_q <= 1'b0;
        end else begin
            eq_lo_q  <= eq_lo_d;
            eq_hi_q  <= eq_hi_d;
            match_q  <= match_c;
            int_st_q <= int_st_d;
        end
    end

    assign int_st  = int_st_q;
    assign tim_int = int_st_q & int_en;

`ifdef TIM_INT_OVF_EN
    localparam int unsigned MISS_W = 4;
    localparam logic [MISS_W-1:0] MISS_MAX = MISS_W'(15);

    logic [MISS_W-1:0] miss_cnt_q, miss_cnt_d;
    logic              int_ovf_q, int_ovf_d;

    // Count rises that arrive while status is still pending; a clear wins here
    // because a same-cycle rise is absorbed by the set, not missed.
    always_comb begin
        miss_cnt_d = miss_cnt_q;
        int_ovf_d  = 1'b0;

        if (clr_c) begin
            miss_cnt_d = '0;
        end else if (rise_c && int_st_q && (miss_cnt_q != MISS_MAX)) begin
            miss_cnt_d = miss_cnt_q + MISS_W'(1);
        end
        int_ovf_d = (miss_cnt_d != '0);
    end

    // Missed-event counter and overflow flag registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            miss_cnt_q <= '0;
            int_ovf_q  <= 1'b0;
        end else begin
            miss_cnt_q <= miss_cnt_d;
            int_ovf_q  <= int_ovf_d;
        end
    end

    assign int_ovf = int_ovf_q;
`endif

endmodule

// File: tb/tb_timer_int_ctrl.sv
// Self-checking bench for timer_int_ctrl: directed scenarios followed by
// randomized traffic, compared against a cycle-level behavioural model.
module tb_timer_int_ctrl;

    logic        clk;
    logic        rst_n;
    logic [63:0] cnt;
    logic [63:0] tcmp;
    logic        int_en;
    logic        wr_sel;
    logic [31:0] wdata;
    logic [3:0]  pstrb;
    logic        dut_int_st;
    logic        dut_tim_int;
`ifdef TIM_INT_OVF_EN
    logic        dut_int_ovf;
`endif

    timer_int_ctrl #(.HALF_W(32), .CLR_BIT(0)) dut (
        .sys_clk     (clk),
        .sys_rst_n   (rst_n),
        .cnt         (cnt),
        .tcmp        (tcmp),
        .int_en      (int_en),
        .tisr_wr_sel (wr_sel),
        .wdata       (wdata),
        .pstrb       (pstrb),
`ifdef TIM_INT_OVF_EN
        .int_ovf     (dut_int_ovf),
`endif
        .int_st      (dut_int_st),
        .tim_int     (dut_tim_int)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic st;
        logic ti;
        logic ovf;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model state: status, last two equality samples, missed events.
    logic m_st;
    logic m_e1;
    logic m_e2;
    int   m_miss;

    task automatic model_reset();
        m_st   = 1'b0;
        m_e1   = 1'b1;
        m_e2   = 1'b1;
        m_miss = 0;
    endtask

    // One clock edge of the reference: a rise is "equal last sample, unequal the one before".
    task automatic model_edge();
        logic rise;
        logic clr;
        rise = m_e1 && !m_e2;
        clr  = wr_sel && pstrb[0] && wdata[0];
        if (clr)
            m_miss = 0;
        else if (rise && m_st)
            m_miss = (m_miss < 15) ? m_miss + 1 : 15;
        if (rise)
            m_st = 1'b1;
        else if (clr)
            m_st = 1'b0;
        m_e2 = m_e1;
        m_e1 = (cnt == tcmp);
    endtask

    // Inputs are already set for the coming edge; queue the expectation for the
    // next falling edge, then advance one cycle.
    task automatic step();
        exp_t e;
        if (!rst_n) model_reset();
        e.st  = m_st;
        e.ti  = m_st & int_en;
        e.ovf = (m_miss != 0);
        exp_q.push_back(e);
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
    endtask

    task automatic wr_cycle(input logic [31:0] d, input logic [3:0] s);
        wr_sel = 1'b1;
        wdata  = d;
        pstrb  = s;
        step();
        wr_sel = 1'b0;
        wdata  = '0;
        pstrb  = '0;
    endtask

    task automatic check(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    // Monitor: compare the DUT outputs with the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("int_st", dut_int_st, e.st);
                check("tim_int", dut_tim_int, e.ti);
`ifdef TIM_INT_OVF_EN
                check("int_ovf", dut_int_ovf, e.ovf);
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int r;
        rst_n  = 1'b0;
        cnt    = '0;
        tcmp   = '0;
        int_en = 1'b0;
        wr_sel = 1'b0;
        wdata  = '0;
        pstrb  = '0;
        model_reset();
        @(posedge clk);
        #1;

        // Reset with equality present, then release and hold.
        repeat (3) step();
        rst_n = 1'b1;
        repeat (6) step();

        // Count up through the compare value.
        tcmp   = 64'h0000_0001_0000_0010;
        int_en = 1'b1;
        cnt    = 64'h0000_0001_0000_0008;
        repeat (16) begin
            step();
            cnt = cnt + 64'd1;
        end

        // Ineffective writes, then a valid clear.
        wr_cycle(32'h1, 4'b0010);
        step();
        wr_cycle(32'h0, 4'b0001);
        step();
        wr_cycle(32'h1, 4'b0001);
        repeat (2) step();

        // Set status, then a new rise coinciding with a clear write.
        tcmp = cnt;
        repeat (3) step();
        tcmp = cnt + 64'd5;
        repeat (2) step();
        tcmp = cnt;
        step();
        wr_cycle(32'h1, 4'b0001);
        repeat (3) step();

        // Stalled counter while masked, unmask, clear mid-way.
        wr_cycle(32'h1, 4'b0001);
        tcmp = cnt + 64'd3;
        repeat (2) step();
        int_en = 1'b0;
        tcmp   = cnt;
        repeat (8) step();
        int_en = 1'b1;
        step();
        wr_cycle(32'h1, 4'b0001);
        repeat (10) step();

        // Wrap-around to zero.
        tcmp = '0;
        cnt  = 64'hFFFF_FFFF_FFFF_FFFC;
        repeat (8) begin
            step();
            cnt = cnt + 64'd1;
        end
        wr_cycle(32'h1, 4'b0001);

        // Seventeen rises without clearing, then one clear.
        for (int i = 0; i < 17; i++) begin
            tcmp = cnt + 64'd1;
            step();
            tcmp = cnt;
            step();
        end
        repeat (3) step();
        wr_cycle(32'h1, 4'b0001);
        repeat (3) step();

        // Randomized traffic with occasional asynchronous reset.
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2, 3, 4: cnt = cnt + 64'd1;
                5, 6:          cnt = cnt;
                7:             cnt = tcmp - 64'd2;
                8:             cnt = {cnt[63:32] + 32'($urandom_range(0, 1)), cnt[31:0]};
                default:       cnt = tcmp;
            endcase
            r = $urandom_range(0, 11);
            if (r == 0)
                tcmp = cnt + 64'($urandom_range(0, 4));
            else if (r == 1)
                tcmp = {cnt[63:32] + 32'd1, cnt[31:0]};
            int_en = ($urandom_range(0, 3) != 0);
            wr_sel = ($urandom_range(0, 5) == 0);
            wdata  = $urandom;
            pstrb  = 4'($urandom_range(0, 15));
            rst_n  = ($urandom_range(0, 199) != 0);
            step();
        end
        rst_n  = 1'b1;
        wr_sel = 1'b0;
        repeat (3) step();

        repeat (3) @(posedge clk);
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
